// File: rtl/spi_reg_ctrl.sv
`timescale 1ns/1ps
// SPI register front end: one command byte per cs frame selects a start address,
// then streams burst writes into, or burst reads out of, a byte register file.
module spi_reg_ctrl #(
    parameter int         NREG   = 8,
    parameter logic [7:0] ID_VAL = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    cs,
    output logic [7:0]              tx_data,
    output logic                    tx_load,
    output logic [NREG*8-1:0]       regs,
    output logic                    wr_strobe,
    output logic [$clog2(NREG)-1:0] wr_addr,
    output logic                    err
);
    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

    state_t        state_q, state_d;
    logic          cs_meta_q, cs_s_q, cs_prev_q;
    logic [AW-1:0] addr_q, addr_d;
    logic          oor_q, oor_d;
    logic          err_q, err_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_load_q, tx_load_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    mem_q [NREG];
    logic [7:0]    mem_d [NREG];
    logic          frame_start, frame_end, cmd_oor;

    // cs_prev_q is one stage behind cs_s_q, so these are edges of the synchronized cs.
    assign frame_start = cs_prev_q & ~cs_s_q;
    assign frame_end   = ~cs_prev_q & cs_s_q;
    assign cmd_oor     = int'(rx_data[6:0]) >= NREG;

    // Location 0 is never stored; it always reads back the ID constant.
    function automatic logic [7:0] rd_byte(input logic [AW-1:0] a);
        return (a == '0) ? ID_VAL : mem_q[a];
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        oor_d       = oor_q;
        err_d       = err_q;
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        mem_d       = mem_q;

        if (frame_start) begin
            state_d = CMD;
            err_d   = 1'b0;
            oor_d   = 1'b0;
        end else if (frame_end) begin
            // A byte arriving together with the cs release is dropped here.
            state_d = IDLE;
        end else if (rx_valid) begin
            case (state_q)
                IDLE: begin
                end
                CMD: begin
                    addr_d = rx_data[AW-1:0];
                    oor_d  = cmd_oor;
                    err_d  = err_q | cmd_oor;
                    if (rx_data[7]) begin
                        state_d = WRITE;
                    end else begin
                        state_d   = READ;
                        tx_load_d = 1'b1;
                        tx_data_d = cmd_oor ? 8'h00 : rd_byte(rx_data[AW-1:0]);
                    end
                end
                WRITE: begin
                    if (!oor_q && addr_q != '0) begin
                        mem_d[addr_q] = rx_data;
                        wr_strobe_d   = 1'b1;
                        wr_addr_d     = addr_q;
                    end
                    addr_d = addr_q + 1'b1;
                end
                READ: begin
                    addr_d    = addr_q + 1'b1;
                    tx_load_d = 1'b1;
                    tx_data_d = oor_q ? 8'h00 : rd_byte(addr_q + 1'b1);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_meta_q   <= 1'b1;
            cs_s_q      <= 1'b1;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            addr_q      <= '0;
            oor_q       <= 1'b0;
            err_q       <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_load_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            for (int i = 0; i < NREG; i++) mem_q[i] <= 8'h00;
        end else begin
            cs_meta_q   <= cs;
            cs_s_q      <= cs_meta_q;
            cs_prev_q   <= cs_s_q;
            state_q     <= state_d;
            addr_q      <= addr_d;
            oor_q       <= oor_d;
            err_q       <= err_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            mem_q       <= mem_d;
        end
    end

    always_comb begin
        regs[7:0] = ID_VAL;
        for (int k = 1; k < NREG; k++) regs[8*k +: 8] = mem_q[k];
    end

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign err       = err_q;
endmodule
